// File: rtl/evt_refresh_extract.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// evt_refresh_extract
//
// Consumer-side refresh extractor on the SNE time-event stream. Every
// EVT_UPDATE marker is removed from the stream. It is replaced by a req/ack
// refresh request that carries the timestamp of the EVT_TIME event that
// follows the marker. That EVT_TIME event is held upstream until the engine
// acknowledges the refresh. It is then forwarded unchanged.
//
// Event word layout (32 bits):
//   [31:28] op     : EVT_SPIKE=4'h1, EVT_TIME=4'h2, EVT_UPDATE=4'h3
//   [27:0]  value  : timestamp value for EVT_TIME events
//
// Parameters:
//   REFRESH_RATE : refresh period in cycles; must be a power of two
//   CNT_WIDTH    : width of the saturating refresh counter
//
// Ports:
//   clk_i, rst_ni              : clock, asynchronous active-low reset
//   enable_i                   : extraction enable; low = pure pass-through
//   evt_time_stream_dst_*      : incoming stream (valid/ready/evt)
//   evt_time_stream_src_*      : outgoing stream, with no EVT_UPDATE when enabled
//   refresh_req_o/refresh_ack_i: refresh handshake with the neuron engine
//   refresh_time_o             : timestamp of the pending/last refresh
//   refresh_cnt_o              : completed refreshes, saturating at all-ones
//   err_o                      : sticky sequence error
//
// Optional feature: define EVT_REFRESH_EXTRACT_CHECK_EN to enable the
// sequence checker. It flags a non-TIME follower, or a misaligned TIME
// follower, of an UPDATE marker. Without the macro, err_o is tied low.
// -----------------------------------------------------------------------------
module evt_refresh_extract #(
    parameter int unsigned REFRESH_RATE = 256,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    // incoming stream
    input  logic                 evt_time_stream_dst_valid,
    output logic                 evt_time_stream_dst_ready,
    input  logic [31:0]          evt_time_stream_dst_evt,
    // outgoing stream
    output logic                 evt_time_stream_src_valid,
    input  logic                 evt_time_stream_src_ready,
    output logic [31:0]          evt_time_stream_src_evt,
    // refresh interface
    output logic                 refresh_req_o,
    input  logic                 refresh_ack_i,
    output logic [27:0]          refresh_time_o,
    output logic [CNT_WIDTH-1:0] refresh_cnt_o,
    output logic                 err_o
);

    localparam int unsigned BIT_WIDTH = $clog2(REFRESH_RATE);

    localparam logic [3:0] EVT_TIME   = 4'h2;
    localparam logic [3:0] EVT_UPDATE = 4'h3;

    // A non-power-of-two rate would make the low-bit alignment meaningless.
    if ((1 << BIT_WIDTH) != REFRESH_RATE) begin : g_bad_rate
        $error("evt_refresh_extract: REFRESH_RATE must be a power of two");
    end

    typedef enum logic [1:0] {
        PASS,
        WAIT_TIME,
        REQ,
        FWD
    } state_e;

    state_e               state_q, state_d;
    logic [27:0]          refresh_time_q;
    logic [CNT_WIDTH-1:0] refresh_cnt_q;

    logic [3:0] dst_op;
    logic       is_update;
    logic       is_time;
    logic       time_ok;    // follower that may start a refresh request
    logic       time_take;  // capture timestamp, move to REQ
    logic       ack_take;   // handshake completes this cycle

    assign dst_op    = evt_time_stream_dst_evt[31:28];
    assign is_update = (dst_op == EVT_UPDATE);
    assign is_time   = (dst_op == EVT_TIME);

`ifdef EVT_REFRESH_EXTRACT_CHECK_EN
    logic seq_err;
    logic err_q;

    assign time_ok = is_time && (evt_time_stream_dst_evt[BIT_WIDTH-1:0] == '0);
    // Any follower that cannot start a request aborts the sequence.
    assign seq_err = (state_q == WAIT_TIME) && evt_time_stream_dst_valid && !time_ok;
`else
    assign time_ok = is_time;
`endif

    assign time_take = (state_q == WAIT_TIME) && evt_time_stream_dst_valid && time_ok;
    assign ack_take  = (state_q == REQ) && refresh_ack_i;

    // ---------------------------------------------------------------------
    // State and data registers
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= PASS;
            refresh_time_q <= '0;
            refresh_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (time_take) begin
                refresh_time_q <= evt_time_stream_dst_evt[27:0];
            end
            if (ack_take && (refresh_cnt_q != '1)) begin
                refresh_cnt_q <= refresh_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

`ifdef EVT_REFRESH_EXTRACT_CHECK_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (seq_err) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    // NOTE: each combinational block assigns defaults first, so no path
    // leaves an output unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PASS: begin
                if (enable_i && evt_time_stream_dst_valid && is_update) begin
                    state_d = WAIT_TIME;
                end
            end
            WAIT_TIME: begin
                if (time_take) begin
                    state_d = REQ;
                end
`ifdef EVT_REFRESH_EXTRACT_CHECK_EN
                else if (seq_err) begin
                    // The offending event is still upstream; PASS handles it.
                    state_d = PASS;
                end
`endif
            end
            REQ: begin
                if (refresh_ack_i) begin
                    state_d = FWD;
                end
            end
            FWD: begin
                if (evt_time_stream_dst_valid && evt_time_stream_src_ready) begin
                    state_d = PASS;
                end
            end
            default: state_d = PASS;
        endcase
    end

    // ---------------------------------------------------------------------
    // Output logic: pass-through by default, overridden per state
    // ---------------------------------------------------------------------
    always_comb begin
        evt_time_stream_src_valid = evt_time_stream_dst_valid;
        evt_time_stream_src_evt   = evt_time_stream_dst_evt;
        evt_time_stream_dst_ready = evt_time_stream_src_ready;
        refresh_req_o             = 1'b0;
        case (state_q)
            PASS: begin
                // Consume and drop the marker without waiting on downstream.
                if (enable_i && evt_time_stream_dst_valid && is_update) begin
                    evt_time_stream_src_valid = 1'b0;
                    evt_time_stream_dst_ready = 1'b1;
                end
            end
            WAIT_TIME: begin
`ifdef EVT_REFRESH_EXTRACT_CHECK_EN
                evt_time_stream_src_valid = 1'b0;
                evt_time_stream_dst_ready = 1'b0;
`else
                // Non-TIME followers flow through; a TIME event is held.
                if (!(evt_time_stream_dst_valid && !is_time)) begin
                    evt_time_stream_src_valid = 1'b0;
                    evt_time_stream_dst_ready = 1'b0;
                end
`endif
            end
            REQ: begin
                refresh_req_o             = 1'b1;
                evt_time_stream_src_valid = 1'b0;
                evt_time_stream_dst_ready = 1'b0;
            end
            FWD: begin
                // The held TIME event is still on dst; the defaults forward it.
            end
            default: begin
                evt_time_stream_src_valid = 1'b0;
                evt_time_stream_dst_ready = 1'b0;
            end
        endcase
    end

    assign refresh_time_o = refresh_time_q;
    assign refresh_cnt_o  = refresh_cnt_q;

endmodule
